// File: rtl/fsm_seq_pkg.sv
// Shared constants for the detector stimulus generator: step table, care masks,
// state encoding and detector input bit positions.
package fsm_seq_pkg;

  localparam int NSTEPS = 12;

  // Detector input bit positions within pat.
  localparam int I1_BIT = 0;
  localparam int I2_BIT = 1;
  localparam int I3_BIT = 2;
  localparam int I4_BIT = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Index 0 holds step 1.
  localparam logic [3:0] STEP_VEC [NSTEPS] = '{
    4'h4, 4'hD, 4'h9, 4'h4, 4'h6, 4'h7, 4'hF, 4'h3, 4'hA, 4'hC, 4'h5, 4'h1
  };

  // Bits the detector examines at each step; flipping them breaks the advance.
  localparam logic [3:0] CARE_MASK [NSTEPS] = '{
    4'h4, 4'h9, 4'h4, 4'h5, 4'hB, 4'h1, 4'h8, 4'hC, 4'h9, 4'h6, 4'h9, 4'h4
  };

endpackage

// File: rtl/fsm_seq_rom.sv
// Step lookup: step number 1..12 -> {vector, care mask}; other indices give zeros.
module fsm_seq_rom
  import fsm_seq_pkg::*;
(
  input  logic [3:0] idx,
  output logic [3:0] vec,
  output logic [3:0] mask
);

  always_comb begin
    vec  = 4'h0;
    mask = 4'h0;
    if (idx >= 4'd1 && idx <= 4'(NSTEPS)) begin
      vec  = STEP_VEC[idx - 4'd1];
      mask = CARE_MASK[idx - 4'd1];
    end
  end

endmodule

// File: rtl/fsm_seq_gen.sv
// Drives the 12-step detector walk on pat, each step held DWELL cycles, with
// optional single-step corruption that sends the detector back to s1.
module fsm_seq_gen
  import fsm_seq_pkg::*;
#(
  parameter int DWELL = 5,
  parameter int CW    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       inject_err,
  input  logic [3:0] err_step,
  output logic [3:0] pat,
  output logic [3:0] step_idx,
  output logic       busy,
  output logic       done,
  output logic       aborted
);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    err_q;

  logic [3:0] next_idx;
  logic [3:0] err_sel;
  logic [3:0] rom_vec;
  logic [3:0] rom_mask;
  logic [3:0] next_pat;
  logic       err_valid;
  logic       step_end;

  fsm_seq_rom u_rom (
    .idx  (next_idx),
    .vec  (rom_vec),
    .mask (rom_mask)
  );

  // The ROM is addressed with the step about to be driven so pat can be registered.
  always_comb begin
    err_valid = inject_err && (err_step >= 4'd1) && (err_step <= 4'(NSTEPS));
    next_idx  = (state == IDLE) ? 4'd1 : step_idx + 4'd1;
    err_sel   = (state == IDLE) ? (err_valid ? err_step : 4'd0) : err_q;
    next_pat  = rom_vec ^ ((next_idx == err_sel) ? rom_mask : 4'h0);
    step_end  = (cnt == CW'(DWELL - 1));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      err_q    <= 4'd0;
      pat      <= 4'h0;
      step_idx <= 4'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pat      <= 4'h0;
          step_idx <= 4'd0;
          busy     <= 1'b0;
          done     <= 1'b0;
          if (start) begin
            state    <= DRIVE;
            err_q    <= err_sel;
            aborted  <= 1'b0;
            cnt      <= '0;
            step_idx <= 4'd1;
            pat      <= next_pat;
            busy     <= 1'b1;
          end
        end
        DRIVE: begin
          if (step_end) begin
            cnt <= '0;
            // A corrupted step ends the run early; the detector is already back in s1.
            if (step_idx == err_q || step_idx == 4'(NSTEPS)) begin
              state    <= FINISH;
              aborted  <= (step_idx == err_q);
              pat      <= 4'h0;
              step_idx <= 4'd0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              step_idx <= next_idx;
              pat      <= next_pat;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        FINISH: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
